// File: rtl/npu_pkg.sv
// Shared definitions for the NPU host load sequencer: FSM states, register map, mode codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package npu_pkg;

   // Load sequencer states; the numeric encoding is visible in STATUS[2:0]
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_L_IMG  = 3'd1,
      ST_L_C12  = 3'd2,
      ST_L_C34  = 3'd3,
      ST_L_C5   = 3'd4,
      ST_L_DONE = 3'd5,
      ST_INFER  = 3'd6
   } state_e;

   // Avalon register map (word addresses)
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DATA   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

   // control_reg mode values seen by mem_top (also the CTRL command values)
   localparam logic [31:0] MODE_IDLE  = 32'd0;
   localparam logic [31:0] MODE_LOAD  = 32'd1;
   localparam logic [31:0] MODE_INFER = 32'd2;

   // Default phase word counts
   localparam int DEF_IMG_WORDS = 224;
   localparam int DEF_C12_WORDS = 320;
   localparam int DEF_C34_WORDS = 9248;
   localparam int DEF_C5_WORDS  = 9248;

   // Fixed load order: image, conv1/2, conv3/4, conv5, then done
   function automatic state_e next_phase(input state_e s);
      case (s)
         ST_L_IMG: return ST_L_C12;
         ST_L_C12: return ST_L_C34;
         ST_L_C34: return ST_L_C5;
         ST_L_C5:  return ST_L_DONE;
         default:  return s;
      endcase
   endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two.
// Latency: a pushed word is visible at dout_o/empty_o the cycle after the push.
// Backpressure: full_o blocks pushes, empty_o blocks pops; flush_i wins over push/pop.
module npu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   // Storage write; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/npu_load_ctrl.sv
// Host load/control sequencer feeding mem_top; optional checksum under NPU_LOAD_CHKSUM_EN.
// Latency: host DATA word reaches writedata/wr_valid 2 cycles after acceptance; readdata 1 cycle.
// Backpressure: waitrequest stalls a DATA write while the payload FIFO is full.
module npu_load_ctrl
   import npu_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int IMG_WORDS  = DEF_IMG_WORDS,
   parameter int C12_WORDS  = DEF_C12_WORDS,
   parameter int C34_WORDS  = DEF_C34_WORDS,
   parameter int C5_WORDS   = DEF_C5_WORDS,
   parameter int CNT_W      = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [1:0]  address,
   input  logic [31:0] avs_writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic [31:0] writedata,
   output logic        wr_valid,
   output logic [31:0] control_reg,
   input  logic [7:0]  D_OUT
);

   localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_WORDS - 1);
   localparam logic [CNT_W-1:0] C12_LAST = CNT_W'(C12_WORDS - 1);
   localparam logic [CNT_W-1:0] C34_LAST = CNT_W'(C34_WORDS - 1);
   localparam logic [CNT_W-1:0] C5_LAST  = CNT_W'(C5_WORDS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, phase_last;
   logic             err_q, err_d;
   logic             wr_valid_q, wr_valid_d;
   logic [31:0]      writedata_q, writedata_d;
   logic [31:0]      control_reg_q, control_reg_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [15:0]      result_hi;

   logic        ctrl_wr, data_wr, in_load;
   logic        ctrl_load, ctrl_idle, ctrl_infer, flush;
   logic        push, pop;
   logic        fifo_full, fifo_empty;
   logic [31:0] fifo_dout;

   assign ctrl_wr    = chipselect & write & (address == ADDR_CTRL);
   assign data_wr    = chipselect & write & (address == ADDR_DATA);
   assign ctrl_load  = ctrl_wr & (avs_writedata == MODE_LOAD);
   assign ctrl_idle  = ctrl_wr & (avs_writedata == MODE_IDLE);
   assign ctrl_infer = ctrl_wr & (avs_writedata == MODE_INFER);
   assign flush      = ctrl_load | ctrl_idle;
   assign in_load    = (state_q inside {ST_L_IMG, ST_L_C12, ST_L_C34, ST_L_C5});
   assign push       = data_wr & in_load & ~fifo_full;
   assign pop        = in_load & ~fifo_empty;

   // A push that coincides with a pop while full still stalls: full is the registered occupancy
   assign waitrequest = data_wr & fifo_full;
   assign readdata    = readdata_q;
   assign writedata   = writedata_q;
   assign wr_valid    = wr_valid_q;
   assign control_reg = control_reg_q;

   npu_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .push_i  (push),
      .din_i   (avs_writedata),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Last-word index of the phase currently being loaded
   always_comb begin
      phase_last = IMG_LAST;
      case (state_q)
         ST_L_C12: phase_last = C12_LAST;
         ST_L_C34: phase_last = C34_LAST;
         ST_L_C5:  phase_last = C5_LAST;
         default:  phase_last = IMG_LAST;
      endcase
   end

   // Next state: pops walk the phases, then host CTRL commands override
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (pop) begin
         if (cnt_q == phase_last) begin
            cnt_d   = '0;
            state_d = next_phase(state_q);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (data_wr && !in_load) err_d = 1'b1;
      if (ctrl_wr) begin
         if (ctrl_load) begin
            state_d = ST_L_IMG;
            cnt_d   = '0;
            err_d   = 1'b0;
         end else if (ctrl_infer) begin
            if (state_q == ST_L_DONE) state_d = ST_INFER;
            else                      err_d   = 1'b1;
         end else if (ctrl_idle) begin
            // The word popped this cycle is discarded, so it is not counted
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Output stage: payload formatting, mode register and host readback mux
   always_comb begin
      wr_valid_d  = pop & ~flush;
      writedata_d = writedata_q;
      if (wr_valid_d) begin
         writedata_d = (state_q == ST_L_IMG) ? fifo_dout : {24'b0, fifo_dout[7:0]};
      end
      case (state_q)
         ST_IDLE:  control_reg_d = MODE_IDLE;
         ST_INFER: control_reg_d = MODE_INFER;
         default:  control_reg_d = MODE_LOAD;
      endcase
      readdata_d = readdata_q;
      if (chipselect && read) begin
         case (address)
            ADDR_CTRL:   readdata_d = {30'b0, control_reg_q[1:0]};
            ADDR_STATUS: readdata_d = 32'({cnt_q, err_q, fifo_full, fifo_empty, state_q});
            ADDR_RESULT: readdata_d = {result_hi, 8'b0, D_OUT};
            default:     readdata_d = '0;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         wr_valid_q    <= 1'b0;
         writedata_q   <= '0;
         control_reg_q <= '0;
         readdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         wr_valid_q    <= wr_valid_d;
         writedata_q   <= writedata_d;
         control_reg_q <= control_reg_d;
         readdata_q    <= readdata_d;
      end
   end

`ifdef NPU_LOAD_CHKSUM_EN
   logic [15:0] chk_q, chk_d;

   // Wrapping byte sum of every emitted payload word; parameter words carry zero upper bytes
   always_comb begin
      chk_d = chk_q;
      if (ctrl_load) begin
         chk_d = '0;
      end else if (wr_valid_q) begin
         chk_d = chk_q + 16'(writedata_q[7:0]) + 16'(writedata_q[15:8])
                       + 16'(writedata_q[23:16]) + 16'(writedata_q[31:24]);
      end
   end

   // Checksum register
   always_ff @(posedge clk) begin
      if (reset) chk_q <= '0;
      else       chk_q <= chk_d;
   end

   assign result_hi = chk_q;
`else
   assign result_hi = 16'h0000;
`endif

endmodule
